// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes one instruction per cycle and
// presents the XLEN-wide immediate from a registered output backed by a skid slot.
module imm_gen_pipe #(
  parameter int XLEN       = 32,
  parameter bit SHAMT_ZEXT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ImmExt,
  output logic [2:0]      imm_fmt,
  output logic            illegal
);

  // Handshake: a word moves on a side only in a cycle where both valid and
  // ready are high; valid never depends on ready, and a producer holding valid
  // keeps its data stable until the transfer happens.

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [5:0]      shamt;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];

  always_comb begin
    imm32   = '0;
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    shamt   = (XLEN == 64) ? instruction[25:20] : {1'b0, instruction[24:20]};
    case (opcode)
      7'b0010011: begin
        if (SHAMT_ZEXT && (funct3 == 3'b001 || funct3 == 3'b101)) begin
          dec_fmt = FMT_SHAMT;
        end else begin
          dec_fmt = FMT_I;
          imm32   = {{20{instruction[31]}}, instruction[31:20]};
        end
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_fmt = FMT_I;
        imm32   = {{20{instruction[31]}}, instruction[31:20]};
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        imm32   = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        imm32   = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        imm32   = {instruction[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        imm32   = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
      end
      default: dec_ill = 1'b1;
    endcase
    // Shift amounts are unsigned; every other format widens from bit 31.
    if (dec_fmt == FMT_SHAMT) dec_imm = XLEN'(shamt);
    else                      dec_imm = XLEN'($signed(imm32));
  end

  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  logic [2:0]      skid_fmt;
  logic            skid_ill;
  logic            accept;
  logic            out_free;

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      ImmExt     <= '0;
      imm_fmt    <= FMT_NONE;
      illegal    <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_fmt   <= FMT_NONE;
      skid_ill   <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid <= 1'b1;
        ImmExt    <= skid_imm;
        imm_fmt   <= skid_fmt;
        illegal   <= skid_ill;
        // The skid slot refills only if a new word arrives as it drains.
        skid_valid <= accept;
        if (accept) begin
          skid_imm <= dec_imm;
          skid_fmt <= dec_fmt;
          skid_ill <= dec_ill;
        end
      end else begin
        out_valid <= accept;
        if (accept) begin
          ImmExt  <= dec_imm;
          imm_fmt <= dec_fmt;
          illegal <= dec_ill;
        end
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_imm   <= dec_imm;
      skid_fmt   <= dec_fmt;
      skid_ill   <= dec_ill;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are scored against an arithmetic reference of the immediate rules.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SHAMT_ZEXT(1'b1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instruction(instruction), .out_valid(out_valid32), .out_ready(out_ready),
    .ImmExt(imm32), .imm_fmt(fmt32), .illegal(illegal32)
  );

  imm_gen_pipe #(.XLEN(64), .SHAMT_ZEXT(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instruction(instruction), .out_valid(out_valid64), .out_ready(out_ready),
    .ImmExt(imm64), .imm_fmt(fmt64), .illegal(illegal64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Interpret an n-bit field as a two's-complement number.
  function automatic longint sx(input longint x, input int n);
    if (x >= (longint'(1) << (n - 1))) return x - (longint'(1) << n);
    return x;
  endfunction

  function automatic void ref_dec(input logic [31:0] i, input int xlen,
                                  output logic [63:0] v, output logic [2:0] f,
                                  output logic il);
    longint r;
    logic [6:0] op;
    op = i[6:0];
    r  = 0;
    f  = 3'd0;
    il = 1'b0;
    if (op == 7'h13 && (i[14:12] == 3'd1 || i[14:12] == 3'd5)) begin
      f = 3'd6;
      r = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
    end else if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73) begin
      f = 3'd1;
      r = sx(longint'(i[31:20]), 12);
    end else if (op == 7'h23) begin
      f = 3'd2;
      r = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
    end else if (op == 7'h63) begin
      f = 3'd3;
      r = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
             longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
    end else if (op == 7'h37 || op == 7'h17) begin
      f = 3'd4;
      r = sx(longint'(i[31:12]), 20) * 4096;
    end else if (op == 7'h6f) begin
      f = 3'd5;
      r = sx(longint'(i[31]) * (1 << 20) + longint'(i[19:12]) * 4096 +
             longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
    end else begin
      il = 1'b1;
    end
    v = (xlen == 64) ? 64'(r) : {32'b0, r[31:0]};
  endfunction

  // One clock cycle: drive inputs, check DUT state against the model at the
  // falling edge, then advance the model across the rising edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    logic acc, con;
    logic [63:0] ev;
    logic [2:0]  ef;
    logic        ei;
    in_valid    = v;
    instruction = ins;
    out_ready   = ordy;
    flush       = fl;
    @(negedge clk);
    check("in_ready32", 64'(in_ready32), 64'(exp_q.size() < 2));
    check("in_ready64", 64'(in_ready64), 64'(exp_q.size() < 2));
    check("out_valid32", 64'(out_valid32), 64'(exp_q.size() != 0));
    check("out_valid64", 64'(out_valid64), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      ref_dec(exp_q[0], 32, ev, ef, ei);
      check("imm32", {32'b0, imm32}, ev);
      check("fmt32", 64'(fmt32), 64'(ef));
      check("ill32", 64'(illegal32), 64'(ei));
      ref_dec(exp_q[0], 64, ev, ef, ei);
      check("imm64", imm64, ev);
      check("fmt64", 64'(fmt64), 64'(ef));
      check("ill64", 64'(illegal64), 64'(ei));
    end
    acc = v && in_ready32;
    con = out_valid32 && ordy;
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (con) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ins);
    end
    #1;
  endtask

  // Directed literal check of the current output of both instances.
  task automatic lit(input string tag, input logic [31:0] e32, input logic [63:0] e64,
                     input logic [2:0] f, input logic il);
    check({tag, "_imm32"}, {32'b0, imm32}, {32'b0, e32});
    check({tag, "_imm64"}, imm64, e64);
    check({tag, "_fmt"}, 64'(fmt32), 64'(f));
    check({tag, "_ill"}, 64'(illegal32), 64'(il));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 64'(out_valid32), 64'd0);
    check({tag, "_imm32"}, {32'b0, imm32}, 64'd0);
    check({tag, "_imm64"}, imm64, 64'd0);
    check({tag, "_fmt"}, 64'(fmt32), 64'd0);
    check({tag, "_ill"}, 64'(illegal32), 64'd0);
    check({tag, "_ready"}, 64'(in_ready32), 64'd1);
    check({tag, "_ready64"}, 64'(in_ready64), 64'd1);
  endtask

  logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6f, 7'h33, 7'h0b};

  initial begin
    logic [31:0] r;
    #2;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back stream, one cycle latency
    cycle(1, 32'hFFF00093, 1, 0); lit("I", 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 0);
    cycle(1, 32'hFE112E23, 1, 0); lit("S", 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 0);
    cycle(1, 32'hFE000CE3, 1, 0); lit("B", 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd3, 0);
    cycle(1, 32'h123450B7, 1, 0); lit("U", 32'h12345000, 64'h0000000012345000, 3'd4, 0);
    cycle(1, 32'h0010006F, 1, 0); lit("J", 32'h00000800, 64'h0000000000000800, 3'd5, 0);
    cycle(1, 32'h41F0D093, 1, 0); lit("srai", 32'h0000001F, 64'h000000000000001F, 3'd6, 0);
    cycle(1, 32'h00000033, 1, 0); lit("rtype", 32'h0, 64'h0, 3'd0, 1);
    cycle(1, 32'h800000B7, 1, 0); lit("U64", 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 0);
    cycle(1, 32'h03F09093, 1, 0); lit("slli63", 32'h0000001F, 64'h000000000000003F, 3'd6, 0);
    cycle(0, 32'h0, 1, 0);

    // Backpressure: four offers with the consumer stalled, then drain
    for (int i = 0; i < 4; i++) cycle(1, 32'h00100093 + (i << 20), 0, 0);
    check("bp_in_ready", 64'(in_ready32), 64'd0);
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 1, 0);

    // Flush with two held entries and a word offered in the same cycle
    cycle(1, 32'h00500093, 0, 0);
    cycle(1, 32'h00600093, 0, 0);
    cycle(1, 32'h00700093, 0, 1);
    check("flush_valid", 64'(out_valid32), 64'd0);
    check("flush_ready", 64'(in_ready32), 64'd1);
    cycle(0, 32'h0, 1, 0);

    // Asynchronous reset mid-cycle while full
    cycle(1, 32'hFFF00093, 0, 0);
    cycle(1, 32'hFE112E23, 0, 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 10)];
      cycle(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 40) == 0));
    end
    for (int n = 0; n < 3; n++) cycle(0, 32'h0, 1, 0);
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the RISC-V core's decode path. Accepts one 32-bit instruction per cycle over a valid/ready handshake, classifies its format (I/S/B/U/J, plus shift-amount I variant), sign- or zero-extends the immediate to XLEN bits and presents it one cycle later through a registered output with a 2-entry skid buffer. It replaces the single-cycle combinational immediate generator when decode is split into a pipeline stage.

## Interface
- XLEN, 32, output immediate width; legal values 32 or 64.
- SHAMT_ZEXT, 1, 1: OP-IMM shifts (funct3 001/101) output zero-extended shamt; 0: treat as plain I-type.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all held entries.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- instruction  in  32  raw instruction word.
- out_valid  out  1  ImmExt/imm_fmt/illegal are valid.
- out_ready  in  1  consumer accepts output.
- ImmExt  out  XLEN  extended immediate.
- imm_fmt  out  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 I-shamt.
- illegal  out  1  opcode has no defined immediate format.

## Operation
- Opcode = instruction[6:0]. Decode (all sign extension from instruction[31] to XLEN):
  - 0010011, 0000011, 1100111, 1110011: I, imm = inst[31:20].
  - 0100011: S, imm = {inst[31:25], inst[11:7]}.
  - 1100011: B, imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - 0110111, 0010111: U, imm = {inst[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
  - 1101111: J, imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - 0010011 with funct3 001/101 and SHAMT_ZEXT=1: fmt 6, ImmExt = zero-extended inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64).
  - Any other opcode: fmt 0, ImmExt = 0, illegal = 1.
- Decode is combinational on the input; results are captured in output register (OUT) or skid register (SKID).
- Input accepted when in_valid && in_ready. Output consumed when out_valid && out_ready.
- OUT load rule, each cycle OUT is empty or being consumed: load from SKID if skid_valid, else from accepted input; otherwise OUT holds.
- Accepted input goes to SKID when OUT is full and not consumed, or when SKID supplies OUT in the same cycle.
- Order preserved strictly FIFO; at most 2 entries held.
- flush: out_valid and skid_valid cleared next edge; input offered in the same cycle is dropped (in_ready still reflects pre-flush state). flush has priority over all loads.

## Timing
- Reset values: out_valid 0, ImmExt 0, imm_fmt 0, illegal 0, skid_valid 0, in_ready 1.
- Latency: input accepted at edge N appears on outputs after edge N (1 cycle) when OUT is free.
- Throughput: 1 instruction/cycle with out_ready held high.
- Backpressure: out_ready low with OUT full absorbs one more input into SKID; in_ready falls the following cycle. in_ready is never combinationally dependent on out_ready.
- Empty: out_valid 0 and out_ready ignored. Full (2 entries): in_ready 0, in_valid ignored.
- Simultaneous accept and consume with SKID empty: new result replaces OUT, no bubble.
- Outputs stable while out_valid && !out_ready.
- rst asserted mid-stream: all entries lost immediately, outputs to reset values asynchronously.

## Test plan
- XLEN=32, stream with out_ready=1: 0xFFF00093 -> FFFFFFFF/I; 0xFE112E23 -> FFFFFFFC/S; 0xFE000CE3 -> FFFFFFF8/B; 0x123450B7 -> 12345000/U; 0x0010006F -> 00000800/J; each 1 cycle after accept, back-to-back.
- Shift and illegal: 0x41F0D093 (srai 31) -> 0000001F/fmt 6; 0x00000033 (R-type) -> ImmExt 0, fmt 0, illegal 1.
- Backpressure: 4 inputs with out_ready=0 -> first two held, in_ready 0 after second, order preserved on release, no loss or duplication.
- Flush with 2 entries held plus in_valid -> next cycle out_valid 0, in_ready 1, offered word never appears.
- XLEN=64: 0x800000B7 -> FFFFFFFF80000000/U; 0x03F09093 (slli 63) -> 000000000000003F/fmt 6.
- Async rst asserted mid-cycle while full -> outputs zero immediately, in_ready 1; random valid/ready traffic vs. reference model afterwards.
